// File: rtl/periph_axi_pkg.sv
// -----------------------------------------------------------------------------
// periph_axi_pkg
// Shared types and constants for the peripheral AXI4-Lite master.
//   state_t        : FSM state encoding (3 bits)
//   RESP_*         : AXI response codes
//   resp_is_error  : true for any response other than OKAY
// -----------------------------------------------------------------------------
package periph_axi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // EXOKAY is meaningless for a non-exclusive access, so it is reported
    // as an error along with SLVERR and DECERR.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};
    endfunction

endpackage

// File: rtl/periph_axi_master_if.sv
// -----------------------------------------------------------------------------
// periph_axi_master_if
// AXI4-Lite bus bundle between the peripheral master and the interconnect.
//   AW : M_AWADDR, M_AWPROT, M_AWVALID, M_AWREADY
//   W  : M_WDATA, M_WSTRB, M_WVALID, M_WREADY
//   B  : M_BRESP, M_BVALID, M_BREADY
//   AR : M_ARADDR, M_ARPROT, M_ARVALID, M_ARREADY
//   R  : M_RDATA, M_RRESP, M_RVALID, M_RREADY
// Modports: master (drives requests) and slave (drives responses).
// -----------------------------------------------------------------------------
interface periph_axi_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] M_AWADDR;
    logic [2:0]        M_AWPROT;
    logic              M_AWVALID;
    logic              M_AWREADY;

    logic [DATA_W-1:0] M_WDATA;
    logic [3:0]        M_WSTRB;
    logic              M_WVALID;
    logic              M_WREADY;

    logic [1:0]        M_BRESP;
    logic              M_BVALID;
    logic              M_BREADY;

    logic [ADDR_W-1:0] M_ARADDR;
    logic [2:0]        M_ARPROT;
    logic              M_ARVALID;
    logic              M_ARREADY;

    logic [DATA_W-1:0] M_RDATA;
    logic [1:0]        M_RRESP;
    logic              M_RVALID;
    logic              M_RREADY;

    modport master (
        output M_AWADDR, M_AWPROT, M_AWVALID,
        input  M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID,
        input  M_WREADY,
        input  M_BRESP, M_BVALID,
        output M_BREADY,
        output M_ARADDR, M_ARPROT, M_ARVALID,
        input  M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID,
        output M_RREADY
    );

    modport slave (
        input  M_AWADDR, M_AWPROT, M_AWVALID,
        output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID,
        output M_WREADY,
        output M_BRESP, M_BVALID,
        input  M_BREADY,
        input  M_ARADDR, M_ARPROT, M_ARVALID,
        output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID,
        input  M_RREADY
    );
endinterface

// File: rtl/periph_axi_master.sv
// -----------------------------------------------------------------------------
// periph_axi_master
// Single-beat AXI4-Lite master for peripheral loads/stores. A start level in
// IDLE launches one transaction; the request operands are captured at launch
// and the bus is driven only from those registers. Completion is reported by
// a registered one-cycle pulse with an error flag.
// Ports:
//   Clk, Rst                      : clock, synchronous active-high reset
//   StartAXIRead, StartAXIWrite   : request levels (write wins if both high)
//   Addr, WData, WStrb            : request operands, sampled at launch
//   ReadCompleted, WriteCompleted : one-cycle completion pulses
//   RData                         : last read data, held until next read
//   Error                         : response was not OKAY (completion cycle only)
//   m_axi                         : AXI4-Lite master bus
// -----------------------------------------------------------------------------
module periph_axi_master
    import periph_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              StartAXIRead,
    input  logic              StartAXIWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    input  logic [3:0]        WStrb,
    output logic              ReadCompleted,
    output logic              WriteCompleted,
    output logic [DATA_W-1:0] RData,
    output logic              Error,
    periph_axi_master_if.master m_axi
);

    state_t            state_reg, state_next;
    logic              aw_done_reg, aw_done_next;
    logic              w_done_reg, w_done_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [3:0]        wstrb_reg, wstrb_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              read_completed_reg, read_completed_next;
    logic              write_completed_reg, write_completed_next;
    logic              error_reg, error_next;

    // Handshake controls decode straight from registered state, so a VALID
    // can only fall on the edge that completes its own handshake.
    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    assign aw_valid = (state_reg == WR_REQ) && !aw_done_reg;
    assign w_valid  = (state_reg == WR_REQ) && !w_done_reg;
    assign b_ready  = (state_reg == WR_RESP);
    assign ar_valid = (state_reg == RD_REQ);
    assign r_ready  = (state_reg == RD_DATA);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg           <= IDLE;
            aw_done_reg         <= 1'b0;
            w_done_reg          <= 1'b0;
            addr_reg            <= '0;
            wdata_reg           <= '0;
            wstrb_reg           <= '0;
            rdata_reg           <= '0;
            read_completed_reg  <= 1'b0;
            write_completed_reg <= 1'b0;
            error_reg           <= 1'b0;
        end else begin
            state_reg           <= state_next;
            aw_done_reg         <= aw_done_next;
            w_done_reg          <= w_done_next;
            addr_reg            <= addr_next;
            wdata_reg           <= wdata_next;
            wstrb_reg           <= wstrb_next;
            rdata_reg           <= rdata_next;
            read_completed_reg  <= read_completed_next;
            write_completed_reg <= write_completed_next;
            error_reg           <= error_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        aw_done_next         = aw_done_reg;
        w_done_next          = w_done_reg;
        addr_next            = addr_reg;
        wdata_next           = wdata_reg;
        wstrb_next           = wstrb_reg;
        rdata_next           = rdata_reg;
        read_completed_next  = 1'b0;
        write_completed_next = 1'b0;
        error_next           = 1'b0;

        case (state_reg)
            IDLE: begin
                // Starts are levels; they are only looked at here, so a start
                // still high while busy never produces a second transaction.
                if (StartAXIWrite) begin
                    state_next   = WR_REQ;
                    addr_next    = Addr;
                    wdata_next   = WData;
                    wstrb_next   = WStrb;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else if (StartAXIRead) begin
                    state_next = RD_REQ;
                    addr_next  = Addr;
                    wdata_next = WData;
                    wstrb_next = WStrb;
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order or together.
                aw_done_next = aw_done_reg || (aw_valid && m_axi.M_AWREADY);
                w_done_next  = w_done_reg  || (w_valid  && m_axi.M_WREADY);
                if (aw_done_next && w_done_next) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.M_BVALID) begin
                    state_next           = IDLE;
                    write_completed_next = 1'b1;
                    error_next           = resp_is_error(m_axi.M_BRESP);
                end
            end
            RD_REQ: begin
                if (m_axi.M_ARREADY) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi.M_RVALID) begin
                    state_next          = IDLE;
                    read_completed_next = 1'b1;
                    error_next          = resp_is_error(m_axi.M_RRESP);
                    rdata_next          = m_axi.M_RDATA;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m_axi.M_AWADDR  = addr_reg;
    assign m_axi.M_AWPROT  = 3'b000;
    assign m_axi.M_AWVALID = aw_valid;
    assign m_axi.M_WDATA   = wdata_reg;
    assign m_axi.M_WSTRB   = wstrb_reg;
    assign m_axi.M_WVALID  = w_valid;
    assign m_axi.M_BREADY  = b_ready;
    assign m_axi.M_ARADDR  = addr_reg;
    assign m_axi.M_ARPROT  = 3'b000;
    assign m_axi.M_ARVALID = ar_valid;
    assign m_axi.M_RREADY  = r_ready;

    assign ReadCompleted  = read_completed_reg;
    assign WriteCompleted = write_completed_reg;
    assign RData          = rdata_reg;
    assign Error          = error_reg;

endmodule

// File: doc/periph_axi_master.md
# periph_axi_master

AXI4-Lite master that executes the single-beat peripheral reads and writes requested by the peripheral-access controller. It consumes the controller's `StartAXIRead`/`StartAXIWrite` strobes together with the latched address, data and strobes from the memory stage. It drives the AXI4-Lite interconnect and returns one-cycle `ReadCompleted`/`WriteCompleted` pulses, read data and an error flag. It sits directly downstream of the controller and upstream of the SoC peripheral interconnect.

## Interface
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: data width; only 32 is supported, so strobes are 4 bits.
- `Clk`  in  1  single clock; all logic is on the rising edge.
- `Rst`  in  1  reset, synchronous and active-high.
- `StartAXIRead`  in  1  read request level; it may stay high for many cycles.
- `StartAXIWrite`  in  1  write request level; it may stay high for many cycles.
- `Addr`  in  ADDR_W  byte address, sampled at launch.
- `WData`  in  DATA_W  write data, sampled at launch.
- `WStrb`  in  4  byte strobes, sampled at launch.
- `ReadCompleted`  out  1  one-cycle pulse when read data is valid.
- `WriteCompleted`  out  1  one-cycle pulse when the write response is received.
- `RData`  out  DATA_W  last read data; held until the next read completes.
- `Error`  out  1  high together with a completion pulse if the RESP field is not OKAY.
- AXI AW channel: `M_AWADDR` out ADDR_W, `M_AWPROT` out 3 (fixed 3'b000), `M_AWVALID` out 1, `M_AWREADY` in 1.
- AXI W channel: `M_WDATA` out DATA_W, `M_WSTRB` out 4, `M_WVALID` out 1, `M_WREADY` in 1.
- AXI B channel: `M_BRESP` in 2, `M_BVALID` in 1, `M_BREADY` out 1.
- AXI AR channel: `M_ARADDR` out ADDR_W, `M_ARPROT` out 3 (fixed 3'b000), `M_ARVALID` out 1, `M_ARREADY` in 1.
- AXI R channel: `M_RDATA` in DATA_W, `M_RRESP` in 2, `M_RVALID` in 1, `M_RREADY` out 1.

## Operation
- FSM states and transitions:
  - IDLE: a start launches a transaction.
  - WR_REQ: AW and W are issued independently.
  - WR_RESP: waits for the B handshake.
  - RD_REQ: waits for the AR handshake.
  - RD_DATA: waits for the R handshake.
  - From WR_RESP and RD_DATA the FSM returns to IDLE.
- Launch happens only in IDLE. On launch, `Addr`, `WData` and `WStrb` are captured into registers, and the AXI outputs are driven only from these registers.
- A start seen in any state other than IDLE is ignored. The request is a level and the controller holds it until completion.
- If both starts are high in IDLE, write has priority. The read is not queued.
- WR_REQ:
  - `M_AWVALID` and `M_WVALID` rise together.
  - Each one drops on its own handshake, tracked with flags `aw_done` and `w_done`.
  - When both handshakes are done (they may land in the same cycle or in either order), the FSM moves to WR_RESP.
- WR_RESP: `M_BREADY` is high for the whole state and low everywhere else.
- RD_REQ: `M_ARVALID` stays high until `M_ARREADY`, then the FSM moves to RD_DATA.
- RD_DATA: `M_RREADY` is high for the whole state.
- Once VALID is raised it is never withdrawn before its handshake.
- On the R handshake, `RData` is loaded with `M_RDATA`.
- `Error` is set to `RESP != 2'b00` (SLVERR and DECERR both count as errors). `Error` is valid only in a completion cycle and is 0 otherwise.

## Timing
- Reset values: state IDLE, and every VALID, READY, completion output and `Error` at 0. `RData`, the captured registers and the AXI address/data outputs reset to 0.
- A start sampled at edge N puts VALID high in cycle N+1.
- Completion pulses are registered. A B or R handshake at edge M gives a completion pulse plus `Error` in cycle M+1, and the FSM is already in IDLE in that cycle.
- The earliest new launch is at edge M+1, where the controller's start has already dropped because its Done is clearing. There is no extra idle cycle.
- Minimum latency with a zero-wait slave:
  - Write: start at edge 0, AW/W handshake at edge 1, B handshake at edge 2, `WriteCompleted` in cycle 3.
  - Read: same cycle counts, giving `ReadCompleted` in cycle 3.
- A response arriving with VALID before the FSM reaches the response state is simply held by the slave. The master never samples B or R outside its response state.
- Reset mid-transaction drops all VALID/READY signals within one edge and returns to IDLE. The interconnect shares `Rst`, so this is legal.
- There is no timeout. A slave that never responds stalls the block, and through the controller the pipeline, indefinitely.

## Structure
- Shared package `periph_axi_pkg`:
  - State encoding `IDLE=0`, `WR_REQ=1`, `WR_RESP=2`, `RD_REQ=3`, `RD_DATA=4` (3 bits).
  - AXI response constants `RESP_OKAY=2'b00`, `RESP_EXOKAY=2'b01`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`.
- Single flat module with no sub-module. The AW/W tracking is two flags inline.

## Test plan
- Zero-wait write: `Addr=0x4000_0010`, `WData=0xDEADBEEF`, `WStrb=4'hF`, start held high → AW, W and B handshakes at edges 1 and 2, `WriteCompleted` high only in cycle 3, `Error=0`, exactly one AW.
- Skewed write: `M_WREADY` arrives 3 cycles before `M_AWREADY` → `M_WVALID` drops after its handshake while `M_AWVALID` stays high, and `M_BREADY` rises only after AW completes.
- Read with 4 wait cycles on R, `M_RDATA=0x1234_5678`, `RRESP=OKAY` → `RData=0x12345678` in the `ReadCompleted` cycle and held afterwards; the start held high during busy causes no second AR.
- Error responses: `BRESP=2'b10` → `WriteCompleted` and `Error` high in the same cycle. Then a read with `RRESP=2'b11` → `Error` high with `ReadCompleted`, and `Error` low in the cycles around it.
- `Rst` asserted in RD_DATA → the next cycle is IDLE with `M_RREADY=0` and no completion pulse. A write then launches normally.
- Both starts high in IDLE → only AW and W are issued. Back-to-back launch on the edge right after completion is accepted.
